hazard_ctrl: RTL and testbench

- Pipeline hazard controller for the 5-stage RISC-V core; the producer side of the control decoder's NoOp input.
- Keeps its own shadow of the EX and MEM stage destination info, detects load-use and ID-stage branch operand hazards, and drives NoOp, PC/IF-ID write enables and the IF flush.
- Sits beside the ID stage. Also gates pipeline start-up and flags stall runaway.

---
 rtl/hazard_ctrl_pkg.sv | 26 ++
 rtl/hazard_ctrl_if.sv | 50 +++++
 rtl/hazard_shadow.sv | 69 ++++++
 rtl/hazard_ctrl.sv | 139 +++++++++++++
 tb/tb_hazard_ctrl.sv | 169 ++++++++++++++++
 5 files changed

// File: rtl/hazard_ctrl_pkg.sv
// Shared constants for the hazard controller: RV32 opcodes, FSM encoding and
// the register-use classification of each opcode.
package hazard_ctrl_pkg;

  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_STALL = 2'd2
  } state_e;

  function automatic logic uses_rs1(input logic [6:0] op);
    return (op == OP_R) || (op == OP_I) || (op == OP_LW) ||
           (op == OP_SW) || (op == OP_BEQ);
  endfunction

  function automatic logic uses_rs2(input logic [6:0] op);
    return (op == OP_R) || (op == OP_SW) || (op == OP_BEQ);
  endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// ID-stage <-> hazard controller bundle. Handshake-free: all signals are
// per-cycle levels; the controller answers combinationally in the same cycle.
interface hazard_ctrl_if #(
  parameter int REG_AW = 5,
  parameter int CNT_W  = 32
);
  import hazard_ctrl_pkg::*;

  logic              start_i;
  logic [6:0]        IDOp_i;
  logic [REG_AW-1:0] IDRs1_i;
  logic [REG_AW-1:0] IDRs2_i;
  logic [REG_AW-1:0] IDRd_i;
  logic              IDRegWrite_i;
  logic              IDMemRead_i;
  logic              BranchEq_i;
  logic              NoOp_o;
  logic              PCWrite_o;
  logic              IFIDWrite_o;
  logic              Flush_o;
  logic              Err_o;
`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_W-1:0]  StallCnt_o;
  logic [CNT_W-1:0]  FlushCnt_o;
`endif
  // Debug view: FSM state and {ex_rd, ex_rw, ex_mr, mem_rd, mem_rw, mem_mr}
  state_e              dbg_state;
  logic [2*REG_AW+3:0] dbg_shadow;

  modport master (
    output start_i, IDOp_i, IDRs1_i, IDRs2_i, IDRd_i,
           IDRegWrite_i, IDMemRead_i, BranchEq_i,
    input  NoOp_o, PCWrite_o, IFIDWrite_o, Flush_o, Err_o,
`ifdef HAZARD_PERF_CNT_EN
    input  StallCnt_o, FlushCnt_o,
`endif
    input  dbg_state, dbg_shadow
  );

  modport slave (
    input  start_i, IDOp_i, IDRs1_i, IDRs2_i, IDRd_i,
           IDRegWrite_i, IDMemRead_i, BranchEq_i,
    output NoOp_o, PCWrite_o, IFIDWrite_o, Flush_o, Err_o,
`ifdef HAZARD_PERF_CNT_EN
    output StallCnt_o, FlushCnt_o,
`endif
    output dbg_state, dbg_shadow
  );

endinterface

// File: rtl/hazard_shadow.sv
// Two-stage EX/MEM shadow of destination info. A killed slot enters EX as
// all zeros, which is exactly what a bubble looks like downstream.
module hazard_shadow #(
  parameter int REG_AW = 5
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              en_i,
  input  logic              kill_i,
  input  logic [REG_AW-1:0] id_rd_i,
  input  logic              id_rw_i,
  input  logic              id_mr_i,
  output logic [REG_AW-1:0] ex_rd_o,
  output logic              ex_rw_o,
  output logic              ex_mr_o,
  output logic [REG_AW-1:0] mem_rd_o,
  output logic              mem_rw_o,
  output logic              mem_mr_o
);

  logic [REG_AW-1:0] ex_rd_q, ex_rd_d, mem_rd_q, mem_rd_d;
  logic              ex_rw_q, ex_rw_d, mem_rw_q, mem_rw_d;
  logic              ex_mr_q, ex_mr_d, mem_mr_q, mem_mr_d;

  always_comb begin
    ex_rd_d  = '0;
    ex_rw_d  = 1'b0;
    ex_mr_d  = 1'b0;
    mem_rd_d = '0;
    mem_rw_d = 1'b0;
    mem_mr_d = 1'b0;
    if (en_i) begin
      mem_rd_d = ex_rd_q;
      mem_rw_d = ex_rw_q;
      mem_mr_d = ex_mr_q;
      if (!kill_i) begin
        ex_rd_d = id_rd_i;
        ex_rw_d = id_rw_i;
        ex_mr_d = id_mr_i;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ex_rd_q  <= '0;
      ex_rw_q  <= 1'b0;
      ex_mr_q  <= 1'b0;
      mem_rd_q <= '0;
      mem_rw_q <= 1'b0;
      mem_mr_q <= 1'b0;
    end else begin
      ex_rd_q  <= ex_rd_d;
      ex_rw_q  <= ex_rw_d;
      ex_mr_q  <= ex_mr_d;
      mem_rd_q <= mem_rd_d;
      mem_rw_q <= mem_rw_d;
      mem_mr_q <= mem_mr_d;
    end
  end

  assign ex_rd_o  = ex_rd_q;
  assign ex_rw_o  = ex_rw_q;
  assign ex_mr_o  = ex_mr_q;
  assign mem_rd_o = mem_rd_q;
  assign mem_rw_o = mem_rw_q;
  assign mem_mr_o = mem_mr_q;

endmodule

// File: rtl/hazard_ctrl.sv
// Load-use / ID-branch hazard controller with start gating and stall-runaway
// flag. Define HAZARD_PERF_CNT_EN to add saturating stall/flush counters.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int REG_AW    = 5,
  parameter int MAX_STALL = 2,
  parameter int CNT_W     = 32
) (
  input logic          clk_i,
  input logic          rst_i,
  hazard_ctrl_if.slave bus
);

  localparam int SCNT_W = $clog2(MAX_STALL + 2);

  state_e            state_q, state_d;
  logic [SCNT_W-1:0] scnt_q, scnt_d;
  logic              err_q, err_d;

  logic [REG_AW-1:0] ex_rd, mem_rd;
  logic              ex_rw, ex_mr, mem_rw, mem_mr;
  logic              active, stall, is_beq, rs1_used, rs2_used;
  logic              ex_match, mem_match, h_lu, h_bex, h_bmem;
  logic              noop, pc_write, flush;

  always_comb begin
    active    = (state_q != ST_IDLE);
    rs1_used  = uses_rs1(bus.IDOp_i);
    rs2_used  = uses_rs2(bus.IDOp_i);
    is_beq    = (bus.IDOp_i == OP_BEQ);
    // x0 is hardwired, so a pending write to it can never be a dependency
    ex_match  = (ex_rd != '0) &&
                ((rs1_used && ex_rd == bus.IDRs1_i) || (rs2_used && ex_rd == bus.IDRs2_i));
    mem_match = (mem_rd != '0) &&
                ((rs1_used && mem_rd == bus.IDRs1_i) || (rs2_used && mem_rd == bus.IDRs2_i));
    h_lu      = ex_mr && ex_match;
    h_bex     = is_beq && ex_rw && ex_match;
    h_bmem    = is_beq && mem_mr && mem_match;
    stall     = h_lu || h_bex || h_bmem;
    noop      = active ? stall : 1'b1;
    pc_write  = active && !stall;
    // A stalled branch is not resolved yet; it re-evaluates after the bubble
    flush     = active && !stall && is_beq && bus.BranchEq_i;
  end

  always_comb begin
    state_d = state_q;
    scnt_d  = scnt_q;
    err_d   = err_q;
    unique case (state_q)
      ST_IDLE: begin
        scnt_d = '0;
        if (bus.start_i) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (stall) begin
          state_d = ST_STALL;
          scnt_d  = SCNT_W'(1);
        end
      end
      ST_STALL: begin
        if (stall) begin
          if (scnt_q != '1) scnt_d = scnt_q + SCNT_W'(1);
          if (scnt_q >= SCNT_W'(MAX_STALL)) err_d = 1'b1;
        end else begin
          state_d = ST_RUN;
          scnt_d  = '0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (active && !bus.start_i) begin
      state_d = ST_IDLE;
      scnt_d  = '0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      scnt_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      scnt_q  <= scnt_d;
      err_q   <= err_d;
    end
  end

  hazard_shadow #(.REG_AW(REG_AW)) u_shadow (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .en_i     (active),
    .kill_i   (noop || !bus.start_i),
    .id_rd_i  (bus.IDRd_i),
    .id_rw_i  (bus.IDRegWrite_i),
    .id_mr_i  (bus.IDMemRead_i),
    .ex_rd_o  (ex_rd),
    .ex_rw_o  (ex_rw),
    .ex_mr_o  (ex_mr),
    .mem_rd_o (mem_rd),
    .mem_rw_o (mem_rw),
    .mem_mr_o (mem_mr)
  );

  assign bus.NoOp_o      = noop;
  assign bus.PCWrite_o   = pc_write;
  assign bus.IFIDWrite_o = pc_write;
  assign bus.Flush_o     = flush;
  assign bus.Err_o       = err_q;
  assign bus.dbg_state   = state_q;
  assign bus.dbg_shadow  = {ex_rd, ex_rw, ex_mr, mem_rd, mem_rw, mem_mr};

`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (active && stall && stall_cnt_q != '1) stall_cnt_d = stall_cnt_q + CNT_W'(1);
    if (flush && flush_cnt_q != '1)           flush_cnt_d = flush_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign bus.StallCnt_o = stall_cnt_q;
  assign bus.FlushCnt_o = flush_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: a per-cycle instruction table with expected
// outputs, plus hand sequences for stall runaway and mid-stall reset.
module tb_hazard_ctrl;
  import hazard_ctrl_pkg::*;

  localparam logic [6:0] OP_LUI = 7'b0110111;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   passed = 0;

  always #5 clk = ~clk;

  hazard_ctrl_if #(.REG_AW(5), .CNT_W(32)) bus ();

  hazard_ctrl #(.REG_AW(5), .MAX_STALL(2), .CNT_W(32)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  typedef struct {
    logic       start;
    logic [6:0] op;
    logic [4:0] rs1, rs2, rd;
    logic       rw, mr, beq;
    logic       noop, pcw, flush;
  } vec_t;

  vec_t vecs[22];

  function automatic vec_t mk(input logic start, input logic [6:0] op,
                              input logic [4:0] rs1, input logic [4:0] rs2,
                              input logic [4:0] rd, input logic rw, input logic mr,
                              input logic beq, input logic noop, input logic pcw,
                              input logic flush);
    vec_t v;
    v.start = start; v.op = op; v.rs1 = rs1; v.rs2 = rs2; v.rd = rd;
    v.rw = rw; v.mr = mr; v.beq = beq; v.noop = noop; v.pcw = pcw; v.flush = flush;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic drive_id(input logic start, input logic [6:0] op, input logic [4:0] rs1,
                          input logic [4:0] rs2, input logic [4:0] rd, input logic rw,
                          input logic mr, input logic beq);
    bus.start_i      = start;
    bus.IDOp_i       = op;
    bus.IDRs1_i      = rs1;
    bus.IDRs2_i      = rs2;
    bus.IDRd_i       = rd;
    bus.IDRegWrite_i = rw;
    bus.IDMemRead_i  = mr;
    bus.BranchEq_i   = beq;
  endtask

  task automatic check_outs(input string tag, input logic noop, input logic pcw,
                            input logic flush, input logic err);
    check({tag, ".noop"},  {31'd0, bus.NoOp_o},      {31'd0, noop});
    check({tag, ".pcw"},   {31'd0, bus.PCWrite_o},   {31'd0, pcw});
    check({tag, ".ifidw"}, {31'd0, bus.IFIDWrite_o}, {31'd0, pcw});
    check({tag, ".flush"}, {31'd0, bus.Flush_o},     {31'd0, flush});
    check({tag, ".err"},   {31'd0, bus.Err_o},       {31'd0, err});
  endtask

  initial begin
    //               start op      rs1 rs2 rd rw mr beq  noop pcw flush
    vecs[0]  = mk(1, OP_I,   0, 0, 0, 1, 0, 0,  1, 0, 0); // IDLE, start seen
    vecs[1]  = mk(1, OP_I,   0, 0, 0, 1, 0, 0,  0, 1, 0); // first RUN cycle
    vecs[2]  = mk(1, OP_LW,  0, 0, 5, 1, 1, 0,  0, 1, 0); // lw x5
    vecs[3]  = mk(1, OP_R,   5, 1, 6, 1, 0, 0,  1, 0, 0); // add x6,x5,x1: load-use
    vecs[4]  = mk(1, OP_R,   5, 1, 6, 1, 0, 0,  0, 1, 0);
    vecs[5]  = mk(1, OP_LW,  0, 0, 5, 1, 1, 0,  0, 1, 0); // lw x5
    vecs[6]  = mk(1, OP_BEQ, 5, 1, 0, 0, 0, 1,  1, 0, 0); // beq x5,x1: H_lu
    vecs[7]  = mk(1, OP_BEQ, 5, 1, 0, 0, 0, 1,  1, 0, 0); // H_bmem
    vecs[8]  = mk(1, OP_BEQ, 5, 1, 0, 0, 0, 1,  0, 1, 1); // resolved, taken
    vecs[9]  = mk(1, OP_R,   2, 3, 7, 1, 0, 0,  0, 1, 0); // add x7,x2,x3
    vecs[10] = mk(1, OP_BEQ, 7, 0, 0, 0, 0, 1,  1, 0, 0); // beq x7,x0: H_bex
    vecs[11] = mk(1, OP_BEQ, 7, 0, 0, 0, 0, 1,  0, 1, 1);
    vecs[12] = mk(1, OP_I,   0, 0, 0, 1, 0, 0,  0, 1, 0); // flush lasted one cycle
    vecs[13] = mk(1, OP_LW,  1, 0, 0, 1, 1, 0,  0, 1, 0); // lw x0,0(x1)
    vecs[14] = mk(1, OP_R,   0, 0, 6, 1, 0, 0,  0, 1, 0); // add x6,x0,x0: no hazard
    vecs[15] = mk(1, OP_LW,  0, 0, 5, 1, 1, 0,  0, 1, 0); // lw x5
    vecs[16] = mk(1, OP_LUI, 5, 5, 8, 1, 0, 0,  0, 1, 0); // lui uses no regs
    vecs[17] = mk(1, OP_LW,  0, 0, 9, 1, 1, 0,  0, 1, 0); // lw x9
    vecs[18] = mk(1, OP_SW,  2, 9, 0, 0, 0, 0,  1, 0, 0); // sw x9 on rs2: load-use
    vecs[19] = mk(1, OP_SW,  2, 9, 0, 0, 0, 0,  0, 1, 0);
    vecs[20] = mk(0, OP_I,   0, 0, 0, 1, 0, 0,  0, 1, 0); // start drop, still RUN
    vecs[21] = mk(0, OP_I,   0, 0, 0, 1, 0, 0,  1, 0, 0); // back in IDLE

    drive_id(0, OP_I, 0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    check_outs("reset", 1, 0, 0, 0);
    check("reset.state",  {30'd0, bus.dbg_state}, {30'd0, ST_IDLE});
    check("reset.shadow", {18'd0, bus.dbg_shadow}, 32'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    for (int i = 0; i < 22; i++) begin
      drive_id(vecs[i].start, vecs[i].op, vecs[i].rs1, vecs[i].rs2, vecs[i].rd,
               vecs[i].rw, vecs[i].mr, vecs[i].beq);
      @(negedge clk);
      check_outs($sformatf("vec%0d", i), vecs[i].noop, vecs[i].pcw, vecs[i].flush, 1'b0);
      @(posedge clk);
      #1;
    end

`ifdef HAZARD_PERF_CNT_EN
    check("perf.stall", bus.StallCnt_o, 32'd5);
    check("perf.flush", bus.FlushCnt_o, 32'd2);
`endif

    // Stall runaway: pin EX to a pending load of x5 so the stall never clears
    drive_id(1, OP_I, 0, 0, 0, 1, 0, 0);
    @(negedge clk);
    check_outs("run.idle", 1, 0, 0, 0);
    @(posedge clk);
    #1;
    force dut.ex_mr = 1'b1;
    force dut.ex_rd = 5'd5;
    drive_id(1, OP_R, 5, 1, 6, 1, 0, 0);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check_outs($sformatf("runaway%0d", c), 1, 0, 0, 0);
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    check_outs("runaway.err", 1, 0, 0, 1);
    @(posedge clk);
    #1;
    drive_id(1, OP_I, 0, 0, 0, 1, 0, 0);
    @(negedge clk);
    check_outs("err.sticky", 0, 1, 0, 1);
    @(posedge clk);
    #1;
    drive_id(1, OP_R, 5, 1, 6, 1, 0, 0);
    @(negedge clk);
    check_outs("restall", 1, 0, 0, 1);

    // Asynchronous reset in the middle of a stall
    #2;
    rst = 1'b1;
    #1;
    check_outs("midrst", 1, 0, 0, 0);
    check("midrst.state", {30'd0, bus.dbg_state}, {30'd0, ST_IDLE});
    release dut.ex_mr;
    release dut.ex_rd;
    #1;
    check("midrst.shadow", {18'd0, bus.dbg_shadow}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check_outs("post_rst", 1, 0, 0, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
